// File: rtl/axis_stream_splitter.sv
// Splits packed 64-bit beats {ch0[23:0], ch1[23:0], pad[15:0]} onto two 24-bit AXI4-Stream channels.
// Mode 0 forwards ch0 only in 6-beat packets; mode 1 forwards both fields in 3-beat packets.
module axis_stream_splitter #(
   parameter int unsigned MODE0_PKT_LEN = 6,
   parameter int unsigned MODE1_PKT_LEN = 3,
   parameter int unsigned CNT_W         = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [63:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [23:0] m_axis_tdata_0,
   output logic        m_axis_tvalid_0,
   input  logic        m_axis_tready_0,
   output logic        m_axis_tlast_0,
   output logic [23:0] m_axis_tdata_1,
   output logic        m_axis_tvalid_1,
   input  logic        m_axis_tready_1,
   output logic        m_axis_tlast_1,
   input  logic        config_mode,
   input  logic        status_clear,
   output logic        status_packets_size_mismatch,
   output logic        status_pad_nonzero
);

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, last_idx;
   logic             mode_q, mode_d;
   logic             active_mode, free_0, free_1;
   logic             accept, end_beat, mismatch_set, pad_set;

   // Mode is sampled from config only between packets; mid-packet the latched mode governs.
   assign active_mode   = (state_q == IDLE) ? config_mode : mode_q;
   assign last_idx      = active_mode ? CNT_W'(MODE1_PKT_LEN - 1) : CNT_W'(MODE0_PKT_LEN - 1);
   assign free_0        = !m_axis_tvalid_0 || m_axis_tready_0;
   assign free_1        = !m_axis_tvalid_1 || m_axis_tready_1;
   assign s_axis_tready = active_mode ? (free_0 && free_1) : free_0;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign end_beat      = s_axis_tlast || (cnt_q == last_idx);
   assign mismatch_set  = accept && (s_axis_tlast != (cnt_q == last_idx));
   assign pad_set       = accept && (s_axis_tdata[15:0] != 16'h0000);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      if (accept) begin
         if (state_q == IDLE) begin
            mode_d = config_mode;
         end
         if (end_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            state_d = IN_PKT;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_axis_tdata_0  <= '0;
         m_axis_tvalid_0 <= 1'b0;
         m_axis_tlast_0  <= 1'b0;
      end else if (accept) begin
         m_axis_tdata_0  <= s_axis_tdata[63:40];
         m_axis_tvalid_0 <= 1'b1;
         m_axis_tlast_0  <= end_beat;
      end else if (m_axis_tready_0) begin
         m_axis_tvalid_0 <= 1'b0;
      end
   end

   // Channel 1 drains on its own, so a mode-1 beat can still be pending after a switch to mode 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_axis_tdata_1  <= '0;
         m_axis_tvalid_1 <= 1'b0;
         m_axis_tlast_1  <= 1'b0;
      end else if (accept && active_mode) begin
         m_axis_tdata_1  <= s_axis_tdata[39:16];
         m_axis_tvalid_1 <= 1'b1;
         m_axis_tlast_1  <= end_beat;
      end else if (m_axis_tready_1) begin
         m_axis_tvalid_1 <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         status_packets_size_mismatch <= 1'b0;
         status_pad_nonzero           <= 1'b0;
      end else begin
         if (mismatch_set) begin
            status_packets_size_mismatch <= 1'b1;
         end else if (status_clear) begin
            status_packets_size_mismatch <= 1'b0;
         end
         if (pad_set) begin
            status_pad_nonzero <= 1'b1;
         end else if (status_clear) begin
            status_pad_nonzero <= 1'b0;
         end
      end
   end

endmodule

// File: doc/axis_stream_splitter.md
Name: axis_stream_splitter

Overview:
- Inverse of the team's two-channel stream combiner.
- Accepts 64-bit AXI4-Stream beats formatted as {ch0[23:0], ch1[23:0], 16'h0} and splits them onto two 24-bit AXI4-Stream outputs.
- Mode 0: single-channel, 6-beat packets; upper field goes to channel 0 only. Mode 1: interleaved, 3-beat packets; both fields are emitted.
- Sits between the 64-bit fabric stream and per-channel sample consumers. Flags framing and padding errors.

Parameters:
MODE0_PKT_LEN, 6, beats per packet in mode 0
MODE1_PKT_LEN, 3, beats per packet in mode 1
CNT_W, 8, width of beat counter; must hold max(PKT_LEN)-1

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_axis_tdata  in  64  packed input beat
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of packet
m_axis_tdata_0  out  24  channel 0 data
m_axis_tvalid_0  out  1  channel 0 valid
m_axis_tready_0  in  1  channel 0 ready
m_axis_tlast_0  out  1  channel 0 end of packet
m_axis_tdata_1  out  24  channel 1 data
m_axis_tvalid_1  out  1  channel 1 valid
m_axis_tready_1  in  1  channel 1 ready
m_axis_tlast_1  out  1  channel 1 end of packet
config_mode  in  1  0 = single channel, 1 = interleaved
status_clear  in  1  synchronous clear of sticky status bits
status_packets_size_mismatch  out  1  sticky: input tlast not on the expected beat
status_pad_nonzero  out  1  sticky: s_axis_tdata[15:0] != 0 on an accepted beat

Behaviour:
- Reset (reset_n is asynchronous, active-low; clock is clk): every output, counter, latched mode and status bit clears to 0; FSM goes to IDLE. Reset mid-packet discards held data immediately, with no partial tlast.
- Output register per channel: holds data, valid and last. valid_n clears when tready_n is high; a new load in the same cycle keeps it set.
- Channel slot free: free_n = !m_axis_tvalid_n || m_axis_tready_n.
- Active mode: equals config_mode in IDLE; equals mode_q in IN_PKT.
- s_axis_tready is combinational:
  - Active mode 0: free_0.
  - Active mode 1: free_0 && free_1.
  - A stalled channel therefore blocks both channels in mode 1.
- Accept = s_axis_tvalid && s_axis_tready. On accept, outputs load on the next clock edge (latency 1):
  - Mode 0: ch0 data = s_axis_tdata[63:40]. Ch1 is not loaded.
  - Mode 1: ch0 data = [63:40] and ch1 data = [39:16]. Both load in the same cycle.
- Beat counter cnt (0 .. LEN-1), where LEN is the parameter for the active mode.
  - end_beat = s_axis_tlast || (cnt == LEN-1).
  - On an accepted end_beat: loaded channel(s) get tlast = 1, and cnt returns to 0.
  - Otherwise, on accept: cnt increments.
- Mismatch detection on accept sets status_packets_size_mismatch when either holds:
  - s_axis_tlast = 1 with cnt != LEN-1 (early tlast), or
  - s_axis_tlast = 0 with cnt == LEN-1 (missing tlast; the block force-terminates the packet).
- Padding check: status_pad_nonzero is set on any accepted beat with [15:0] != 0. Data is still forwarded.
- Sticky bits: clear only on status_clear. If status_clear and a set condition occur in the same cycle, set wins.
- FSM:
  - IDLE: cnt = 0. On accept, latch mode_q = config_mode. Go to IN_PKT, unless the beat is itself end_beat, in which case stay in IDLE.
  - IN_PKT: mode_q governs; config_mode changes are ignored. On an accepted end_beat, go to IDLE.
- Mode switch at a packet boundary: channel 1 may still hold a pending mode-1 beat while mode-0 packets proceed. Channels drain independently.
- Full throughput: one beat per cycle when consumer readies are held high.
- Outputs hold stable while valid && !ready (AXI rule).

Test Plan:
1. Mode 0, readies high, six beats 0xAAAAA1_000000_0000 .. 0xAAAAA6_..., tlast on beat 6 -> ch0 emits 0xAAAAA1..0xAAAAA6 on consecutive cycles with tlast on the 6th; ch1 never valid; no status bits set.
2. Mode 1, three beats {0x111111,0x222222,0} .. {0x333333,0x444444,0}, tlast on beat 3 -> ch0 emits 0x111111..0x333333 and ch1 emits 0x222222..0x444444, both with tlast on beat 3.
3. Mode 1, m_axis_tready_1 low for 4 cycles mid-packet -> s_axis_tready drops; ch1 data holds stable; no beats lost or duplicated; packet completes once tready_1 returns high.
4. Mode 1, tlast on beat 2 -> tlast on output beat 2, mismatch set. Next packet is 3 beats with no tlast at all -> forced tlast on beat 3. status_clear pulse -> mismatch returns to 0.
5. config_mode toggles 0->1 after beat 2 of a mode-0 packet -> remaining 4 beats still routed ch0-only; the following packet is interleaved. Beat with [15:0] = 0x0001 -> status_pad_nonzero = 1 and data still forwarded.
6. reset_n asserted low mid-packet (beat 3 held, ready low) -> all valids, tlasts and status bits read 0 asynchronously. After release, a fresh 6-beat mode-0 packet frames correctly from cnt = 0.
